binning_nxn: RTL



---
 rtl/binning_pkg.sv | 49 ++++
 rtl/binning_line_ram.sv | 36 +++
 rtl/binning_nxn.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/binning_pkg.sv
`default_nettype none
// ============================================================================
// Module      : binning_pkg
// Description : Shared types, widths and mode helpers for binning_nxn.
// Revision    : 1.0 - initial release
// ============================================================================
package binning_pkg;

    typedef enum logic [1:0] {
        BIN_BYPASS = 2'd0,
        BIN_2X2    = 2'd1,
        BIN_4X4    = 2'd2
    } bin_mode_t;

    // HACC_W / VACC_W: room for 4 and 16 summed pixels respectively
    function automatic int hacc_w(input int pixel_width);
        return pixel_width + 2;
    endfunction

    function automatic int vacc_w(input int pixel_width);
        return pixel_width + 4;
    endfunction

    function automatic bin_mode_t decode_mode(input logic [1:0] mode);
        case (mode)
            2'd1:    return BIN_2X2;
            2'd2:    return BIN_4X4;
            default: return BIN_BYPASS;
        endcase
    endfunction

    function automatic logic [2:0] k_of(input bin_mode_t mode);
        case (mode)
            BIN_2X2: return 3'd2;
            BIN_4X4: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [2:0] shift_of(input bin_mode_t mode);
        case (mode)
            BIN_2X2: return 3'd2;
            BIN_4X4: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/binning_line_ram.sv
`default_nettype none
// ============================================================================
// Module      : binning_line_ram
// Description : Simple dual-port line buffer, 1-clk registered read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module binning_line_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/binning_nxn.sv
`default_nettype none
// ============================================================================
// Module      : binning_nxn
// Description : Runtime N x N pixel binning (bypass / 2x2 / 4x4), average or
//               saturated sum. Macro BINNING_ROUND_EN: round-to-nearest average.
// Revision    : 1.0 - initial release
// ============================================================================
module binning_nxn
    import binning_pkg::*;
#(
    parameter int PIXEL_WIDTH   = 8,
    parameter int CH_COUNT      = 1,
    parameter int LINE_SIZE_MAX = 4096
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      bin_mode,
    input  logic                            sum_en,
    input  logic [CH_COUNT*PIXEL_WIDTH-1:0] di_i,
    input  logic                            de_i,
    input  logic                            hs_i,
    input  logic                            vs_i,
    output logic [CH_COUNT*PIXEL_WIDTH-1:0] do_o,
    output logic                            de_o,
    output logic                            hs_o,
    output logic                            vs_o
);

    localparam int DW        = CH_COUNT * PIXEL_WIDTH;
    localparam int HACC_W    = hacc_w(PIXEL_WIDTH);
    localparam int VACC_W    = vacc_w(PIXEL_WIDTH);
    localparam int RAM_DEPTH = LINE_SIZE_MAX / 2;
    localparam int AW        = $clog2(RAM_DEPTH);
    localparam int PCW       = $clog2(LINE_SIZE_MAX + 1);
    localparam logic [PCW-1:0]    PIX_LIMIT = PCW'(LINE_SIZE_MAX);
    localparam logic [VACC_W-1:0] PIX_MAX   = VACC_W'((1 << PIXEL_WIDTH) - 1);

    localparam logic [0:0] ST_WAIT_FRAME = 1'b0;
    localparam logic [0:0] ST_ACTIVE     = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic                       vs_prev_q, vs_prev_d, hs_prev_q, hs_prev_d;
    bin_mode_t                  mode_q, mode_d;
    logic                       sum_en_q, sum_en_d;
    logic [1:0]                 xcnt_q, xcnt_d, ycnt_q, ycnt_d;
    logic [AW-1:0]              xaddr_q, xaddr_d;
    logic [PCW-1:0]             pcnt_q, pcnt_d;
    logic                       line_de_q, line_de_d;
    logic [CH_COUNT*HACC_W-1:0] hacc_q, hacc_d;
    logic                       s1_valid_q, s1_valid_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic [CH_COUNT*VACC_W-1:0] s1_sum_q, s1_sum_d;
    logic [DW-1:0]              do_q, do_d;
    logic                       de_q, de_d, hs_q, hs_d, vs_q, vs_d;

    logic                       w_vs_rise, w_vs_fall, w_hs_rise, w_hs_fall, w_frame_run;
    logic [1:0]                 w_kmax, w_cur_xcnt;
    logic [AW-1:0]              w_cur_xaddr;
    logic [PCW-1:0]             w_cur_pcnt;
    logic                       w_cur_line_de, w_pix, w_grp_first, w_grp_done;
    logic [CH_COUNT*HACC_W-1:0] w_hsum;
    logic [CH_COUNT*VACC_W-1:0] w_vsum, w_rd_data;
    logic [2:0]                 w_shift;
    logic [VACC_W-1:0]          w_rnd, w_sum, w_avg, w_sat;

    assign w_vs_rise = vs_i & ~vs_prev_q;
    assign w_vs_fall = ~vs_i & vs_prev_q;
    assign w_hs_rise = hs_i & ~hs_prev_q;
    assign w_hs_fall = ~hs_i & hs_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_WAIT_FRAME;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_FRAME: if (w_vs_rise) state_d = ST_ACTIVE;
            default:       if (w_vs_fall) state_d = ST_WAIT_FRAME;
        endcase
    end

    // A restart edge is a configuration cycle, never a pixel cycle
    always_comb begin
        w_frame_run = (state_q == ST_ACTIVE) && !w_vs_rise;
    end

    always_comb begin
        w_kmax        = 2'(k_of(mode_q) - 3'd1);
        w_cur_xcnt    = w_hs_fall ? 2'd0 : xcnt_q;
        w_cur_xaddr   = w_hs_fall ? '0 : xaddr_q;
        w_cur_pcnt    = w_hs_fall ? '0 : pcnt_q;
        w_cur_line_de = w_hs_fall ? 1'b0 : line_de_q;
        w_pix         = w_frame_run && de_i && (w_cur_pcnt < PIX_LIMIT);
        w_grp_first   = (w_cur_xcnt == 2'd0);
        w_grp_done    = (w_cur_xcnt == w_kmax);
        w_hsum        = '0;
        w_vsum        = '0;
        for (int ch = 0; ch < CH_COUNT; ch++) begin
            w_hsum[ch*HACC_W +: HACC_W] = (w_grp_first ? HACC_W'(0) : hacc_q[ch*HACC_W +: HACC_W])
                                        + HACC_W'(di_i[ch*PIXEL_WIDTH +: PIXEL_WIDTH]);
            w_vsum[ch*VACC_W +: VACC_W] = ((ycnt_q == 2'd0) ? VACC_W'(0) : w_rd_data[ch*VACC_W +: VACC_W])
                                        + VACC_W'(w_hsum[ch*HACC_W +: HACC_W]);
        end
    end

    binning_line_ram #(
        .DEPTH (RAM_DEPTH),
        .WIDTH (CH_COUNT * VACC_W),
        .AW    (AW)
    ) u_line_ram (
        .clk     (clk),
        .wr_en   (w_pix && w_grp_done && (ycnt_q != w_kmax)),
        .wr_addr (w_cur_xaddr),
        .wr_data (w_vsum),
        .rd_en   (w_pix && w_grp_first && (w_kmax != 2'd0)),
        .rd_addr (w_cur_xaddr),
        .rd_data (w_rd_data)
    );

    always_comb begin
        vs_prev_d = vs_i;
        hs_prev_d = hs_i;
        mode_d    = mode_q;
        sum_en_d  = sum_en_q;
        xcnt_d    = xcnt_q;
        ycnt_d    = ycnt_q;
        xaddr_d   = xaddr_q;
        pcnt_d    = pcnt_q;
        line_de_d = line_de_q;
        hacc_d    = hacc_q;
        if (w_vs_rise) begin
            mode_d    = decode_mode(bin_mode);
            sum_en_d  = sum_en;
            xcnt_d    = 2'd0;
            ycnt_d    = 2'd0;
            xaddr_d   = '0;
            pcnt_d    = '0;
            line_de_d = 1'b0;
            hacc_d    = '0;
        end else if (state_q == ST_ACTIVE) begin
            xcnt_d    = w_cur_xcnt;
            xaddr_d   = w_cur_xaddr;
            pcnt_d    = w_cur_pcnt;
            line_de_d = w_cur_line_de | w_pix;
            if (w_pix) begin
                hacc_d = w_hsum;
                xcnt_d = w_grp_done ? 2'd0 : w_cur_xcnt + 2'd1;
                pcnt_d = w_cur_pcnt + PCW'(1);
                if (w_grp_done) xaddr_d = w_cur_xaddr + AW'(1);
            end
            // Empty lines do not advance the row counter
            if (w_hs_rise && (line_de_q || w_pix)) begin
                ycnt_d = (ycnt_q == w_kmax) ? 2'd0 : ycnt_q + 2'd1;
            end
        end
        s1_valid_d = w_pix && w_grp_done && (ycnt_q == w_kmax);
        s1_sum_d   = w_vsum;
        s1_hs_d    = hs_i || !(w_frame_run && (ycnt_q == w_kmax));
        s1_vs_d    = vs_i;
    end

    assign w_shift = shift_of(mode_q);
`ifdef BINNING_ROUND_EN
    assign w_rnd = (w_shift == 3'd0) ? '0 : (VACC_W'(1) << (w_shift - 3'd1));
`else
    assign w_rnd = '0;
`endif

    always_comb begin
        do_d  = do_q;
        w_sum = '0;
        w_avg = '0;
        w_sat = '0;
        for (int ch = 0; ch < CH_COUNT; ch++) begin
            w_sum = s1_sum_q[ch*VACC_W +: VACC_W];
            w_avg = (w_sum + w_rnd) >> w_shift;
            w_sat = (w_sum > PIX_MAX) ? PIX_MAX : w_sum;
            if (s1_valid_q) do_d[ch*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(sum_en_q ? w_sat : w_avg);
        end
        de_d = s1_valid_q;
        hs_d = s1_hs_q;
        vs_d = s1_vs_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_q  <= 1'b1;
            hs_prev_q  <= 1'b1;
            mode_q     <= BIN_BYPASS;
            sum_en_q   <= 1'b0;
            xcnt_q     <= 2'd0;
            ycnt_q     <= 2'd0;
            xaddr_q    <= '0;
            pcnt_q     <= '0;
            line_de_q  <= 1'b0;
            hacc_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_hs_q    <= 1'b1;
            s1_vs_q    <= 1'b0;
            do_q       <= '0;
            de_q       <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b0;
        end else begin
            vs_prev_q  <= vs_prev_d;
            hs_prev_q  <= hs_prev_d;
            mode_q     <= mode_d;
            sum_en_q   <= sum_en_d;
            xcnt_q     <= xcnt_d;
            ycnt_q     <= ycnt_d;
            xaddr_q    <= xaddr_d;
            pcnt_q     <= pcnt_d;
            line_de_q  <= line_de_d;
            hacc_q     <= hacc_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            do_q       <= do_d;
            de_q       <= de_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
        end
    end

    assign do_o = do_q;
    assign de_o = de_q;
    assign hs_o = hs_q;
    assign vs_o = vs_q;

endmodule
`default_nettype wire
